// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_accumulator
// Brief    : Multi-operand carry-save accumulator with single-cycle CPA resolve
// Revision : 1.0
// ============================================================================
module csa_accumulator #(
    parameter int IN_W   = 17,
    parameter int ACC_W  = 24,
    parameter int N_IN   = 3,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    input  logic [N_IN-1:0]        in_en,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [CNT_W-1:0]       out_count
);

    typedef enum logic [0:0] {
        ST_ACC   = 1'b0,
        ST_FINAL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_accept;

    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_count;

    logic [ACC_W-1:0]   w_ext [0:N_IN-1];
    logic [ACC_W-1:0]   w_s   [0:N_IN];
    logic [ACC_W-1:0]   w_c   [0:N_IN];

    // Operand extraction, masking and extension to accumulator width
    genvar k;
    generate
        for (k = 0; k < N_IN; k++) begin : g_operand
            logic [IN_W-1:0] w_op;
            assign w_op = in_data[k*IN_W +: IN_W];
            if (ACC_W > IN_W) begin : g_wide
                if (SIGNED != 0) begin : g_sext
                    assign w_ext[k] = in_en[k] ? {{(ACC_W-IN_W){w_op[IN_W-1]}}, w_op} : '0;
                end else begin : g_zext
                    assign w_ext[k] = in_en[k] ? {{(ACC_W-IN_W){1'b0}}, w_op} : '0;
                end
            end else begin : g_same
                assign w_ext[k] = in_en[k] ? w_op[ACC_W-1:0] : '0;
            end
        end
    endgenerate

    // Cascaded 3:2 stages; each folds one operand into the redundant pair
    assign w_s[0] = r_s;
    assign w_c[0] = r_c;
    generate
        for (k = 0; k < N_IN; k++) begin : g_csa
            logic [ACC_W-1:0] w_maj;
            assign w_maj      = (w_s[k] & w_c[k]) | (w_s[k] & w_ext[k]) | (w_c[k] & w_ext[k]);
            assign w_s[k+1]   = w_s[k] ^ w_c[k] ^ w_ext[k];
            assign w_c[k+1]   = w_maj << 1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = !r_out_valid || out_ready;
                w_accept   = in_valid && w_in_ready;
                if (w_accept && in_last) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_state_nxt = ST_ACC;
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (r_state == ST_FINAL) begin
            // Only place the carry-propagate add appears
            r_out_data  <= r_s + r_c;
            r_out_count <= r_cnt;
            r_out_valid <= 1'b1;
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_s   <= w_s[N_IN];
                r_c   <= w_c[N_IN];
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_accumulator
// Brief    : Directed + random bench for unsigned and signed accumulators
// Revision : 1.0
// ============================================================================
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [50:0] in_data;
    logic [2:0]  in_en;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_u, in_ready_s;
    logic        out_valid_u, out_valid_s;
    logic [23:0] out_data_u, out_data_s;
    logic [7:0]  out_count_u, out_count_s;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integer sums per group, modulo 2^24
    longint m_sum_u, m_sum_s, m_od_u, m_od_s;
    int     m_cnt, m_oc;
    bit     m_final, m_ov;

    always #5 clk = ~clk;

    csa_accumulator #(.IN_W(17), .ACC_W(24), .N_IN(3), .SIGNED(0), .CNT_W(8)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .in_en(in_en), .in_last(in_last),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_count(out_count_u)
    );

    csa_accumulator #(.IN_W(17), .ACC_W(24), .N_IN(3), .SIGNED(1), .CNT_W(8)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_en(in_en), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_count(out_count_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum_u = 0; m_sum_s = 0; m_cnt = 0;
        m_od_u  = 0; m_od_s  = 0; m_oc  = 0;
        m_final = 0; m_ov    = 0;
    endtask

    // One clock cycle: drive, check against model, clock edge, update model
    task automatic cyc(input bit r, input bit v, input logic [2:0] en,
                       input logic [16:0] a0, input logic [16:0] a1, input logic [16:0] a2,
                       input bit last, input bit ordy);
        logic [16:0] ops [3];
        bit exp_rdy, acc;
        ops[0] = a0; ops[1] = a1; ops[2] = a2;
        rst = r; in_valid = v; in_en = en; in_data = {a2, a1, a0};
        in_last = last; out_ready = ordy;
        #1;
        exp_rdy = !m_final && (!m_ov || ordy);
        if (!r) begin
            chk("in_ready_u",  in_ready_u,  exp_rdy);
            chk("in_ready_s",  in_ready_s,  exp_rdy);
            chk("out_valid_u", out_valid_u, m_ov);
            chk("out_valid_s", out_valid_s, m_ov);
            chk("out_data_u",  out_data_u,  m_od_u);
            chk("out_data_s",  out_data_s,  m_od_s);
            chk("out_count_u", out_count_u, m_oc);
            chk("out_count_s", out_count_s, m_oc);
        end
        acc = v && exp_rdy && !r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (m_final) begin
            m_ov = 1; m_od_u = m_sum_u; m_od_s = m_sum_s; m_oc = m_cnt;
            m_sum_u = 0; m_sum_s = 0; m_cnt = 0; m_final = 0;
        end else begin
            if (m_ov && ordy) m_ov = 0;
            if (acc) begin
                for (int i = 0; i < 3; i++) begin
                    if (en[i]) begin
                        m_sum_u += longint'(ops[i]);
                        m_sum_s += longint'($signed(ops[i]));
                    end
                end
                m_sum_u &= 64'hFF_FFFF;
                m_sum_s &= 64'hFF_FFFF;
                m_cnt = (m_cnt + 1) % 256;
                if (last) m_final = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_en = '0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        repeat (3) cyc(1, 0, 3'b000, 0, 0, 0, 0, 0);

        // Reset state
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);
        chk("reset_data", out_data_u, 0);

        // Single beat {5,7,9}
        cyc(0, 1, 3'b111, 17'd5, 17'd7, 17'd9, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("single_sum",   out_data_u,  24'd21);
        chk("single_count", out_count_u, 8'd1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);

        // Four back-to-back full-scale beats
        for (int b = 0; b < 4; b++)
            cyc(0, 1, 3'b111, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, (b == 3), 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("four_sum_u",  out_data_u,  24'h17FFF4);
        chk("four_sum_s",  out_data_s,  24'hFFFFF4);
        chk("four_count",  out_count_u, 8'd4);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);

        // Signed single beat, then masked beat
        cyc(0, 1, 3'b111, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("signed_m3", out_data_s, 24'hFFFFFD);
        cyc(0, 1, 3'b010, 17'd100, 17'd200, 17'd300, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("mask_200", out_data_u, 24'd200);

        // Backpressure with a beat waiting, then release in the same cycle
        repeat (5) cyc(0, 1, 3'b001, 17'd3, 0, 0, 1, 0);
        chk("bp_hold", out_data_u, 24'd200);
        cyc(0, 1, 3'b001, 17'd3, 0, 0, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("bp_next", out_data_u, 24'd3);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);

        // Reset discards a partial group
        cyc(0, 1, 3'b111, 17'd50, 17'd60, 17'd70, 0, 1);
        cyc(0, 1, 3'b111, 17'd50, 17'd60, 17'd70, 0, 1);
        cyc(1, 0, 3'b000, 0, 0, 0, 0, 1);
        cyc(0, 1, 3'b001, 17'd1, 0, 0, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("mid_rst_sum",   out_data_u,  24'd1);
        chk("mid_rst_count", out_count_u, 8'd1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);

        // Empty group with no earlier beats
        cyc(0, 1, 3'b000, 17'd9, 17'd9, 17'd9, 1, 1);
        cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("empty_sum",   out_data_u,  24'd0);
        chk("empty_count", out_count_u, 8'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                3'($urandom), 17'($urandom), 17'($urandom), 17'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
        end
        repeat (4) cyc(0, 0, 3'b000, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
